// File: rtl/binary16_div_issue.sv
// Issue stage for the iterative binary16 divider: buffers operand pairs, resolves
// IEEE special cases locally and hands only normal pairs to the divider, one at a time.
module binary16_div_issue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] div_a,
    output logic [15:0] div_b,
    output logic        div_valid_out,
    input  logic [15:0] div_result,
    input  logic        div_valid_in,
    output logic [15:0] out_result,
    output logic        out_valid,
    input  logic        out_ready
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [15:0] QNAN = 16'h7E00;

    typedef enum logic {IDLE, WAIT} state_t;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop, empty;

    state_t        state_q, state_d;
    logic [15:0]   div_a_d, div_b_d, out_result_d;
    logic          div_valid_d, out_valid_d;

    logic [15:0]   head_a, head_b;
    logic          is_special;
    logic [15:0]   special_code;

    assign in_ready = !rst && (count != CW'(DEPTH));
    assign empty    = (count == '0);
    assign push     = in_valid && in_ready;
    assign head_a   = mem[rd_ptr][31:16];
    assign head_b   = mem[rd_ptr][15:0];

    // Operand storage; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr] <= {in_a, in_b};
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Special-case classification of the FIFO head; subnormals count as zero
    always_comb begin
        logic              sa, sb, sr;
        logic [4:0]        ea, eb;
        logic [9:0]        ma, mb;
        logic              nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        logic signed [6:0] ef;

        sa = head_a[15];  ea = head_a[14:10];  ma = head_a[9:0];
        sb = head_b[15];  eb = head_b[14:10];  mb = head_b[9:0];
        sr = sa ^ sb;
        nan_a  = (ea == 5'd31) && (ma != '0);
        nan_b  = (eb == 5'd31) && (mb != '0);
        inf_a  = (ea == 5'd31) && (ma == '0);
        inf_b  = (eb == 5'd31) && (mb == '0);
        zero_a = (ea == 5'd0);
        zero_b = (eb == 5'd0);
        ef = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 7'sd15
             - $signed({6'b000000, (ma < mb)});

        is_special   = 1'b1;
        special_code = QNAN;
        if (nan_a || nan_b) begin
            special_code = QNAN;
        end else if ((inf_a && inf_b) || (zero_a && zero_b)) begin
            special_code = QNAN;
        end else if (inf_a) begin
            special_code = {sr, 15'h7C00};
        end else if (inf_b) begin
            special_code = {sr, 15'h0000};
        end else if (zero_b) begin
            special_code = {sr, 15'h7C00};
        end else if (zero_a) begin
            special_code = {sr, 15'h0000};
        end else if (ef >= 7'sd31) begin
            special_code = {sr, 15'h7C00};
        end else if (ef <= 7'sd0) begin
            special_code = {sr, 15'h0000};
        end else begin
            is_special = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q       <= IDLE;
            div_a         <= '0;
            div_b         <= '0;
            div_valid_out <= 1'b0;
            out_result    <= '0;
            out_valid     <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_a         <= div_a_d;
            div_b         <= div_b_d;
            div_valid_out <= div_valid_d;
            out_result    <= out_result_d;
            out_valid     <= out_valid_d;
        end
    end

    // Next state and next output values; a pop only happens with the output slot free
    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        div_a_d      = div_a;
        div_b_d      = div_b;
        div_valid_d  = 1'b0;
        out_result_d = out_result;
        out_valid_d  = out_valid;
        if (out_valid && out_ready) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (!empty && !out_valid) begin
                    pop = 1'b1;
                    if (is_special) begin
                        out_result_d = special_code;
                        out_valid_d  = 1'b1;
                    end else begin
                        div_a_d     = head_a;
                        div_b_d     = head_b;
                        div_valid_d = 1'b1;
                        state_d     = WAIT;
                    end
                end
            end
            WAIT: begin
                if (div_valid_in) begin
                    out_result_d = div_result;
                    out_valid_d  = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: doc/binary16_div_issue.md
# binary16_div_issue

Front-end stage for the iterative binary16 divider. Buffers operand pairs in a small FIFO and classifies each pair for IEEE special cases (NaN, infinity, zero, subnormal, exponent overflow/underflow). Special-case results are produced directly. Only normal pairs are issued to the divider, one at a time. Results leave through a single valid/ready output in strict arrival order.

## Interface
- DEPTH, 4: operand FIFO entries (power of two, ≥2).
- clk_in  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_a  input  16  binary16 dividend.
- in_b  input  16  binary16 divisor.
- in_valid  input  1  operand pair present.
- in_ready  output  1  FIFO not full; 0 while rst is high.
- div_a  output  16  registered dividend to divider.
- div_b  output  16  registered divisor to divider.
- div_valid_out  output  1  one-cycle issue pulse to divider data_valid_in.
- div_result  input  16  divider result.
- div_valid_in  input  1  divider result strobe (divider data_valid_out).
- out_result  output  16  final binary16 quotient.
- out_valid  output  1  out_result valid; held until accepted.
- out_ready  input  1  consumer accepts.

## Operation
- Push on in_valid && in_ready. in_ready = !full. A push is refused when full, even if a pop occurs in the same cycle. Pop only from the FSM.
- Field decode per operand: s = bit 15, e = bits 14:10, m = bits 9:0.
  - NaN: e=31, m≠0.
  - Inf: e=31, m=0.
  - Zero: e=0. Subnormals are flushed and treated as zero.
- Sign rule: sr = sa^sb. NaN output is always 0x7E00.
- Classification, first match wins:
  1. Either operand NaN → 0x7E00.
  2. Inf/Inf or 0/0 → 0x7E00.
  3. a Inf → {sr,0x7C00[14:0]}.
  4. b Inf → {sr,15'h0}.
  5. b zero → signed Inf.
  6. a zero → signed zero.
  7. Exponent check on normal pairs: ef = ea − eb + 15 − (ma<mb ? 1:0), computed as a 7-bit signed value. ef ≥ 31 → signed Inf. ef ≤ 0 → signed zero.
  8. Otherwise the pair is normal.
- FSM states: IDLE, WAIT.
  - IDLE: the FSM acts only if the FIFO is non-empty and out_valid==0. It pops the head, then:
    - Special: register the code into out_result, set out_valid=1, stay in IDLE.
    - Normal: register div_a/div_b, pulse div_valid_out for exactly one cycle, go to WAIT.
  - WAIT: when div_valid_in=1, capture div_result into out_result, set out_valid=1, go to IDLE. Nothing else is popped while in WAIT.
- div_valid_in while in IDLE is ignored.
- Output handshake: out_valid and out_result stay stable until out_valid && out_ready. out_valid clears on that edge. No new result is loaded in the same cycle as the handshake.
- Ordering: at most one operation is in flight, so outputs are in FIFO order.

## Timing
- Reset values: in_ready=0 while rst is high, 1 afterwards. div_a=0, div_b=0, div_valid_out=0, out_result=0, out_valid=0. FIFO empty, state IDLE.
- Pair written at edge k into an empty FIFO with out_valid=0:
  - Special: out_valid=1 after edge k+1.
  - Normal: div_valid_out=1 during cycle k+1..k+2.
- Normal result: out_valid=1 the edge after div_valid_in is sampled. This is one cycle of added latency beyond the divider.
- Throughput:
  - Specials: one every 2 cycles when out_ready is held at 1.
  - Normals: bounded by divider latency + 2.
- Reset mid-WAIT or with out_valid=1: everything is dropped, the state returns to IDLE, and the FIFO is emptied. The divider shares rst, so its in-flight operation is aborted too.
- Push and pop in the same cycle, not full: both happen and the count is unchanged.
- Read and write pointers wrap modulo DEPTH. Full/empty is tracked with a count of width log2(DEPTH)+1.

## Test plan
- Normal: push 0x4000/0x3C00. Expect div_valid_out one cycle with div_a=0x4000, div_b=0x3C00. Bench replies div_result=0x4000 → out_result=0x4000.
- Specials, no divider pulse:
  - 0x3C00/0x0000 → 0x7C00.
  - 0xBC00/0x0000 → 0xFC00.
  - 0x0000/0x0000 → 0x7E00.
  - 0x7C01/0x3C00 → 0x7E00.
  - 0x3C00/0x7C00 → 0x0000.
  - 0x0001/0x3C00 → 0x0000 (subnormal flushed).
- Range: 0x7800/0x0400 (ef=44) → 0x7C00. 0x0400/0x7800 (ef=−14) → 0x0000. Neither issues to the divider.
- Backpressure/order: out_ready=0; push 5 mixed pairs with DEPTH=4. in_ready drops after the FIFO fills. Release out_ready and expect all results in push order, with no loss or duplication.
- Spurious strobe: div_valid_in pulsed while IDLE → no out_valid.
- Reset mid-WAIT: assert rst one cycle after div_valid_out. Expect all outputs at reset values and the FIFO empty. A later div_valid_in is ignored and the next push processes normally.
